// File: rtl/vd_speed_cmd.sv
// Command generator for the vehicle speed FSM: steps the FSM toward a latched
// target with single-cycle LR pulses and confirms each step on speed_fb.
module vd_speed_cmd #(
   parameter int W       = 4,
   parameter int SETTLE  = 1,
   parameter int TIMEOUT = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] target,
   input  logic [W-1:0] speed_fb,
   output logic [1:0]   LR,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [W-1:0] steps
);

   // state    | meaning
   // IDLE     | waiting for start, LR held at 00
   // CMP      | compare speed_fb with latched target, choose direction
   // CMD      | LR carries the chosen command for exactly one cycle
   // SETTLE   | LR=00 for SETTLE cycles before looking at feedback
   // WAITMV   | wait for speed_fb to leave the pre-command value, bounded by TIMEOUT
   // DONE     | target reached, done high for this single cycle
   // ERR      | FSM did not respond, err set (sticky)
   typedef enum logic [2:0] {
      S_IDLE,
      S_CMP,
      S_CMD,
      S_SETTLE,
      S_WAITMV,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [1:0] LR_HOLD = 2'b00;
   localparam logic [1:0] LR_INC  = 2'b01;
   localparam logic [1:0] LR_DEC  = 2'b10;

   localparam logic [3:0] SETTLE_LD  = 4'(SETTLE - 1);
   localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT - 1);

   state_t         state_q, state_d;
   logic [W-1:0]   tgt_q, tgt_d;
   logic [W-1:0]   prev_q, prev_d;
   logic [W-1:0]   steps_q, steps_d;
   logic [3:0]     settle_q, settle_d;
   logic [7:0]     tmo_q, tmo_d;
   logic [1:0]     lr_q, lr_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           err_q, err_d;

   always_comb begin
      state_d  = state_q;
      tgt_d    = tgt_q;
      prev_d   = prev_q;
      steps_d  = steps_q;
      settle_d = settle_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      lr_d     = LR_HOLD;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               tgt_d   = target;
               steps_d = '0;
               err_d   = 1'b0;
               state_d = S_CMP;
            end
         end
         S_CMP: begin
            if (speed_fb == tgt_q) begin
               state_d = S_DONE;
            end else if (speed_fb < tgt_q) begin
               lr_d    = LR_INC;
               state_d = S_CMD;
            end else begin
               lr_d    = LR_DEC;
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            prev_d   = speed_fb;
            if (steps_q != '1) begin
               steps_d = steps_q + 1'b1;
            end
            settle_d = SETTLE_LD;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q == '0) begin
               tmo_d   = TIMEOUT_LD;
               state_d = S_WAITMV;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         S_WAITMV: begin
            // any change counts as a completed step; overshoot is fixed up by CMP
            if (speed_fb != prev_q) begin
               state_d = S_CMP;
            end else if (tmo_q == '0) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_CMP) || (state_d == S_CMD) ||
               (state_d == S_SETTLE) || (state_d == S_WAITMV);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         tgt_q    <= '0;
         prev_q   <= '0;
         steps_q  <= '0;
         settle_q <= '0;
         tmo_q    <= '0;
         lr_q     <= LR_HOLD;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         prev_q   <= prev_d;
         steps_q  <= steps_d;
         settle_q <= settle_d;
         tmo_q    <= tmo_d;
         lr_q     <= lr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign LR    = lr_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;
   assign steps = steps_q;

endmodule

// File: tb/tb_vd_speed_cmd.sv
// Directed bench for vd_speed_cmd against a small behavioural vdfsm model.
module tb_vd_speed_cmd;

   localparam int W       = 4;
   localparam int SETTLE  = 1;
   localparam int TIMEOUT = 8;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] target;
   logic [W-1:0] speed_fb;
   logic [1:0]   LR;
   logic         busy;
   logic         done;
   logic         err;
   logic [W-1:0] steps;

   int n_cmp;
   int n_mis;

   vd_speed_cmd #(.W(W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .target   (target),
      .speed_fb (speed_fb),
      .LR       (LR),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .steps    (steps)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // vdfsm model: updates one cycle after LR, saturating, optional freeze
   logic         set_en;
   logic [W-1:0] set_val;
   logic         freeze;
   logic [4:0]   inc_step;
   logic [W-1:0] spd;
   logic [4:0]   spd_sum;

   assign spd_sum  = {1'b0, spd} + inc_step;
   assign speed_fb = spd;

   always @(posedge clk) begin
      if (set_en) begin
         spd <= set_val;
      end else if (!freeze) begin
         if (LR == 2'b01) begin
            spd <= (spd_sum > 5'd15) ? 4'd15 : spd_sum[3:0];
         end else if (LR == 2'b10) begin
            spd <= (spd == 4'd0) ? 4'd0 : spd - 4'd1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // LR monitor: command counts, pulse width, spacing, legality, last three commands
   int         n_inc;
   int         n_dec;
   int         zero_run;
   logic       had_cmd;
   logic [1:0] lr_prev;
   logic [5:0] lr_hist;

   initial begin
      n_inc = 0; n_dec = 0; zero_run = 0;
      had_cmd = 1'b0; lr_prev = 2'b00; lr_hist = '0;
   end

   always @(negedge clk) begin
      if (reset) begin
         had_cmd  = 1'b0;
         zero_run = 0;
         lr_prev  = 2'b00;
      end else begin
         if (LR != 2'b00) begin
            chk("lr_legal", 32'(LR != 2'b11), 1);
            chk("lr_width", 32'(lr_prev == 2'b00), 1);
            if (had_cmd) chk("lr_gap", 32'(zero_run >= SETTLE + 1), 1);
            if (LR == 2'b01) n_inc++;
            if (LR == 2'b10) n_dec++;
            lr_hist  = {lr_hist[3:0], LR};
            had_cmd  = 1'b1;
            zero_run = 0;
         end else begin
            zero_run++;
         end
         lr_prev = LR;
      end
   end

   task automatic set_spd(input logic [W-1:0] v);
      @(posedge clk); #1;
      set_en = 1'b1; set_val = v;
      @(posedge clk); #1;
      set_en = 1'b0;
   endtask

   task automatic do_start(input logic [W-1:0] t);
      @(posedge clk); #1;
      start = 1'b1; target = t;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // counts negedges from the CMP cycle until done or err shows up
   task automatic wait_end(input int max_cyc, output int cyc);
      cyc = 0;
      while (cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (done || err) break;
      end
      chk("end_seen", 32'(done | err), 1);
   endtask

   int cyc;
   int inc0, dec0;

   initial begin
      n_cmp = 0; n_mis = 0;
      reset = 1'b1; start = 1'b0; target = '0;
      set_en = 1'b1; set_val = '0; freeze = 1'b0; inc_step = 5'd1;
      repeat (3) @(posedge clk);
      #1 set_en = 1'b0;
      @(negedge clk);
      chk("rst_lr", 32'(LR), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_steps", 32'(steps), 0);
      @(posedge clk); #1 reset = 1'b0;

      // 0 -> 4
      inc0 = n_inc; dec0 = n_dec;
      do_start(4'd4);
      @(negedge clk);
      chk("t1_busy", 32'(busy), 1);
      wait_end(60, cyc);
      chk("t1_lat", 32'(cyc + 1), 18);
      chk("t1_done", 32'(done), 1);
      chk("t1_err", 32'(err), 0);
      chk("t1_steps", 32'(steps), 4);
      chk("t1_inc", 32'(n_inc - inc0), 4);
      chk("t1_dec", 32'(n_dec - dec0), 0);
      chk("t1_spd", 32'(speed_fb), 4);
      @(negedge clk);
      chk("t1_done_pulse", 32'(done), 0);
      chk("t1_busy_after", 32'(busy), 0);

      // 4 -> 1
      inc0 = n_inc; dec0 = n_dec;
      do_start(4'd1);
      wait_end(60, cyc);
      chk("t2_lat", cyc, 14);
      chk("t2_done", 32'(done), 1);
      chk("t2_steps", 32'(steps), 3);
      chk("t2_dec", 32'(n_dec - dec0), 3);
      chk("t2_inc", 32'(n_inc - inc0), 0);

      // target equals current speed
      set_spd(4'd7);
      inc0 = n_inc; dec0 = n_dec;
      do_start(4'd7);
      @(negedge clk);
      chk("t3_done_early", 32'(done), 0);
      wait_end(20, cyc);
      chk("t3_lat", cyc, 1);
      chk("t3_done", 32'(done), 1);
      chk("t3_steps", 32'(steps), 0);
      chk("t3_lr_moves", 32'((n_inc - inc0) + (n_dec - dec0)), 0);

      // frozen FSM at 5, target 9
      set_spd(4'd5);
      freeze = 1'b1;
      inc0 = n_inc;
      do_start(4'd9);
      wait_end(60, cyc);
      chk("t4_lat", cyc, 12);
      chk("t4_err", 32'(err), 1);
      chk("t4_busy", 32'(busy), 0);
      chk("t4_done", 32'(done), 0);
      chk("t4_steps", 32'(steps), 1);
      chk("t4_inc", 32'(n_inc - inc0), 1);
      repeat (3) @(negedge clk);
      chk("t4_err_sticky", 32'(err), 1);
      freeze = 1'b0;
      do_start(4'd5);
      @(negedge clk);
      chk("t4_err_clr", 32'(err), 0);
      wait_end(20, cyc);
      chk("t4_done2", 32'(done), 1);

      // mid-request reset, plus a start while busy
      set_spd(4'd0);
      do_start(4'd15);
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1; target = 4'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("t5_busy", 32'(busy), 1);
      chk("t5_steps1", 32'(steps), 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_lr_cmd2", 32'(LR), 1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("t5_rst_lr", 32'(LR), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_steps", 32'(steps), 0);
      chk("t5_spd", 32'(speed_fb), 2);
      repeat (4) @(negedge clk);
      chk("t5_idle_lr", 32'(LR), 0);
      chk("t5_idle_busy", 32'(busy), 0);

      // overshoot: +2 per increment
      set_spd(4'd0);
      inc_step = 5'd2;
      inc0 = n_inc; dec0 = n_dec;
      do_start(4'd3);
      wait_end(60, cyc);
      chk("t6_lat", cyc, 14);
      chk("t6_done", 32'(done), 1);
      chk("t6_steps", 32'(steps), 3);
      chk("t6_inc", 32'(n_inc - inc0), 2);
      chk("t6_dec", 32'(n_dec - dec0), 1);
      chk("t6_seq", 32'(lr_hist), 32'h16);
      chk("t6_spd", 32'(speed_fb), 3);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
